sol_axil_regs: RTL and testbench
================================

Name: sol_axil_regs

Overview:
- AXI4-Lite slave register file with an integrated solenoid pulse generator.
- Sits behind the interconnect on the logic board and is driven by the system AXI4-Lite master.
- Holds control, pulse length, scratch and status registers.
- Drives one solenoid output pulse of programmable length on each software fire command.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; 8 word slots, 4 implemented.
- CNT_WIDTH, 16, width of the fire counter in STATUS[31:16].

Ports:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESETN  in  1  synchronous active-low reset
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID  in  1  write address valid
- S_AXI_AWREADY  out  1  write address ready
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte strobes
- S_AXI_WVALID  in  1  write data valid
- S_AXI_WREADY  out  1  write data ready
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID  out  1  write response valid
- S_AXI_BREADY  in  1  write response ready
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID  in  1  read address valid
- S_AXI_ARREADY  out  1  read address ready
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID  out  1  read data valid
- S_AXI_RREADY  in  1  read data ready
- sol_out  out  1  solenoid drive, active level set by CTRL[2]

Behaviour:
- Reset is synchronous on S_AXI_ACLK with S_AXI_ARESETN low. All ready/valid outputs are 0, RESP is 0, RDATA is 0. All registers are 0. The pulse counter is 0. sol_out equals the idle level (0). Reset mid-transaction drops all pending transactions and aborts any pulse the same cycle.
- Address map (word index = addr[4:2]; addr[1:0] ignored):
  - 0 CTRL: [0] ENABLE RW; [1] FIRE write-1 strobe, reads 0; [2] POL RW; others read 0.
  - 1 PULSE_LEN: RW, 32 bits.
  - 2 SCRATCH: RW, 32 bits.
  - 3 STATUS: [0] BUSY RO; [1] OVERRUN W1C; [2] DONE W1C (feature only); [31:16] FIRE_CNT RO, wraps modulo 2^CNT_WIDTH.
  - 4-7: writes ignored, reads return 0; RESP=SLVERR (2'b10).
- Write channel:
  - AW and W are captured independently. AWREADY is high when no AW is latched and BVALID=0; WREADY is the same for W.
  - The write commits in the cycle after both are latched. BVALID rises in that same cycle with BRESP=OKAY or SLVERR, and holds until BREADY.
  - WSTRB masks bytes per lane. FIRE is acted on only when WSTRB[0]=1.
- Read channel:
  - ARREADY is high when RVALID=0.
  - On the AR handshake, RDATA/RRESP are registered from current register state and RVALID rises next cycle. Both hold until RREADY.
- Simultaneous read and write commit to the same register: the read returns the pre-write value.
- Pulse FSM:
  - States IDLE and PULSE.
  - IDLE to PULSE: on a FIRE with ENABLE=1 (ENABLE value after the same write) and PULSE_LEN != 0. The counter loads PULSE_LEN, FIRE_CNT increments, and sol_out = ~POL starts the next cycle.
  - PULSE: the counter decrements each cycle. When it reaches 1, return to IDLE, so sol_out is active for exactly PULSE_LEN cycles.
  - FIRE in PULSE: ignored and OVERRUN set.
  - FIRE with ENABLE=0 or PULSE_LEN=0: no pulse, no count.
  - ENABLE cleared in PULSE: abort to IDLE next cycle.
  - BUSY = (state == PULSE).
  - A PULSE_LEN write during PULSE affects only the next pulse.
  - Idle sol_out = POL.
- W1C clear and hardware set in the same cycle: set wins.

Optional Feature:
- Macro: SOL_REGS_IRQ_EN.
- With it defined:
  - Adds output port irq (1 bit).
  - STATUS[2] DONE sets on each normal PULSE-to-IDLE completion; an abort does not set it.
  - irq = DONE & CTRL[3] (IRQ_EN bit, RW). irq is registered and resets to 0.
- Without it: no irq port; CTRL[3] and STATUS[2] read 0 and writes to them are ignored.

Test Plan:
- Write 0x1,0x2,0x3,0x4 to addrs 0x0,0x4,0x8,0xC, then read back -> CTRL=0x1, PULSE_LEN=0x2, SCRATCH=0x3, STATUS=0x0; all responses OKAY.
- Assert W two cycles before AW to 0x8, data 0xA5A5A5A5, WSTRB=4'b0101 over 0xFFFFFFFF -> readback 0xFFA5FFA5; single BVALID held until BREADY asserted 3 cycles late.
- PULSE_LEN=10, CTRL=0x3 -> sol_out high exactly 10 cycles starting one cycle after the write commit; STATUS reads 0x00010001 mid-pulse and 0x00010000 after.
- FIRE again during the pulse -> pulse length unchanged, STATUS[1]=1, FIRE_CNT=1; write 0x2 to STATUS -> STATUS[1]=0.
- Read 0x14 and write 0x1C -> RRESP=BRESP=2'b10, RDATA=0, no register change.
- Reset low for 1 cycle mid-pulse with a read outstanding -> next cycle sol_out=0, RVALID=0, BVALID=0, all registers 0.

Source files
------------

// File: rtl/sol_axil_regs.sv
// AXI4-Lite register file (CTRL, PULSE_LEN, SCRATCH, STATUS) driving one solenoid pulse per FIRE.
// Define SOL_REGS_IRQ_EN to add the DONE status flag, the CTRL[3] interrupt enable and the irq output.
module sol_axil_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5,
   parameter int CNT_WIDTH          = 16
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
`ifdef SOL_REGS_IRQ_EN
   output logic                            irq,
`endif
   output logic                            sol_out
);

   localparam int DW = C_S_AXI_DATA_WIDTH;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_PULSE = 1'b1;

   function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old,
                                                input logic [DW-1:0] data,
                                                input logic [3:0]    strb);
      logic [DW-1:0] res;
      res = old;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
      end
      return res;
   endfunction

   logic            aw_held;
   logic            w_held;
   logic [2:0]      aw_word;
   logic [DW-1:0]   w_data;
   logic [3:0]      w_strb;
   logic            bvalid;
   logic [1:0]      bresp;
   logic            rvalid;
   logic [DW-1:0]   rdata;
   logic [1:0]      rresp;

   logic            ctrl_en;
   logic            ctrl_pol;
   logic            ctrl_irq_en;
   logic [DW-1:0]   pulse_len;
   logic [DW-1:0]   scratch;
   logic            overrun;
   logic            done_flag;
   logic [CNT_WIDTH-1:0] fire_cnt;
   logic [0:0]      state;
   logic [DW-1:0]   cnt;

   logic            commit;
   logic            wr_ctrl;
   logic            wr_len;
   logic            wr_scr;
   logic            wr_stat;
   logic            en_nxt;
   logic            fire;
   logic            busy;
   logic            start;
   logic            abort;
   logic            finish;
   logic            ovr_set;
   logic [DW-1:0]   rd_data;
   logic [1:0]      rd_resp;

   logic unused_inputs;
   assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   assign S_AXI_AWREADY = !aw_held && !bvalid;
   assign S_AXI_WREADY  = !w_held && !bvalid;
   assign S_AXI_BVALID  = bvalid;
   assign S_AXI_BRESP   = bresp;
   assign S_AXI_ARREADY = !rvalid;
   assign S_AXI_RVALID  = rvalid;
   assign S_AXI_RDATA   = rdata;
   assign S_AXI_RRESP   = rresp;

   // Decode of the committing write; ENABLE seen by FIRE is the value after this write.
   assign commit  = aw_held && w_held;
   assign wr_ctrl = commit && (aw_word == 3'd0) && w_strb[0];
   assign wr_len  = commit && (aw_word == 3'd1);
   assign wr_scr  = commit && (aw_word == 3'd2);
   assign wr_stat = commit && (aw_word == 3'd3) && w_strb[0];
   assign en_nxt  = wr_ctrl ? w_data[0] : ctrl_en;
   assign fire    = wr_ctrl && w_data[1];
   assign busy    = (state == ST_PULSE);
   assign start   = fire && !busy && en_nxt && (pulse_len != '0);
   assign abort   = busy && !en_nxt;
   assign finish  = busy && en_nxt && (cnt == DW'(1));
   assign ovr_set = fire && busy;

   assign sol_out = ctrl_pol ^ busy;

   always_comb begin
      rd_data = '0;
      rd_resp = RESP_OKAY;
      case (S_AXI_ARADDR[4:2])
         3'd0:    rd_data = {{(DW-4){1'b0}}, ctrl_irq_en, ctrl_pol, 1'b0, ctrl_en};
         3'd1:    rd_data = pulse_len;
         3'd2:    rd_data = scratch;
         3'd3:    rd_data = {16'(fire_cnt), 13'b0, done_flag, overrun, busy};
         default: rd_resp = RESP_SLVERR;
      endcase
   end

   // Write address/data capture and response
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         aw_held <= 1'b0;
         w_held  <= 1'b0;
         aw_word <= '0;
         w_data  <= '0;
         w_strb  <= '0;
         bvalid  <= 1'b0;
         bresp   <= RESP_OKAY;
      end else begin
         if (S_AXI_AWVALID && S_AXI_AWREADY) begin
            aw_held <= 1'b1;
            aw_word <= S_AXI_AWADDR[4:2];
         end
         if (S_AXI_WVALID && S_AXI_WREADY) begin
            w_held <= 1'b1;
            w_data <= S_AXI_WDATA;
            w_strb <= S_AXI_WSTRB;
         end
         if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= aw_word[2] ? RESP_SLVERR : RESP_OKAY;
         end else if (bvalid && S_AXI_BREADY) begin
            bvalid <= 1'b0;
         end
      end
   end

   // Read response, sampled from register state in the AR handshake cycle
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         rvalid <= 1'b0;
         rdata  <= '0;
         rresp  <= RESP_OKAY;
      end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
         rvalid <= 1'b1;
         rdata  <= rd_data;
         rresp  <= rd_resp;
      end else if (rvalid && S_AXI_RREADY) begin
         rvalid <= 1'b0;
      end
   end

   // Registers and pulse sequencer
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         ctrl_en   <= 1'b0;
         ctrl_pol  <= 1'b0;
         pulse_len <= '0;
         scratch   <= '0;
         overrun   <= 1'b0;
         fire_cnt  <= '0;
         state     <= ST_IDLE;
         cnt       <= '0;
      end else begin
         if (wr_ctrl) begin
            ctrl_en  <= w_data[0];
            ctrl_pol <= w_data[2];
         end
         if (wr_len) pulse_len <= apply_strb(pulse_len, w_data, w_strb);
         if (wr_scr) scratch   <= apply_strb(scratch, w_data, w_strb);
         overrun <= ovr_set | (overrun & !(wr_stat && w_data[1]));

         case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_PULSE;
                  cnt      <= pulse_len;
                  fire_cnt <= fire_cnt + 1'b1;
               end
            end
            ST_PULSE: begin
               if (abort || finish) state <= ST_IDLE;
               else                 cnt   <= cnt - 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef SOL_REGS_IRQ_EN
   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         ctrl_irq_en <= 1'b0;
         done_flag   <= 1'b0;
         irq         <= 1'b0;
      end else begin
         if (wr_ctrl) ctrl_irq_en <= w_data[3];
         // A normal completion wins over a W1C clear in the same cycle.
         done_flag <= finish | (done_flag & !(wr_stat && w_data[2]));
         irq       <= done_flag & ctrl_irq_en;
      end
   end
`else
   assign ctrl_irq_en = 1'b0;
   assign done_flag   = 1'b0;
`endif

endmodule

// File: tb/tb_sol_axil_regs.sv
// Randomized self-checking bench for sol_axil_regs against a cycle-level behavioural model.
module tb_sol_axil_regs;

`ifdef SOL_REGS_IRQ_EN
   localparam bit IRQ_ON = 1'b1;
`else
   localparam bit IRQ_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [4:0]  araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic        sol_out;
`ifdef SOL_REGS_IRQ_EN
   logic        irq;
`endif

   always #5 clk = ~clk;

   sol_axil_regs dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWPROT  (awprot),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARPROT  (arprot),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready),
`ifdef SOL_REGS_IRQ_EN
      .irq           (irq),
`endif
      .sol_out       (sol_out)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Model: m_left = remaining active pulse cycles; a committed write is queued in pw_*
   bit          m_en, m_pol, m_irqen, m_ovr, m_done, m_irq;
   logic [31:0] m_len, m_scr;
   logic [15:0] m_cnt;
   int          m_left;
   bit          pw_valid;
   logic [4:0]  pw_addr;
   logic [31:0] pw_data;
   logic [3:0]  pw_strb;
   bit          sol_chk_on = 1'b0;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   function automatic logic [33:0] model_read(input logic [4:0] a);
      logic [31:0] d;
      logic [1:0]  r;
      d = 32'h0;
      r = 2'b00;
      case (a[4:2])
         3'd0:    d = {28'h0, m_irqen, m_pol, 1'b0, m_en};
         3'd1:    d = m_len;
         3'd2:    d = m_scr;
         3'd3:    d = {m_cnt, 13'h0, m_done, m_ovr, (m_left != 0)};
         default: r = 2'b10;
      endcase
      return {r, d};
   endfunction

   task automatic model_step();
      bit busy, en_new, fire, done_set;
      int word;
      if (!rst_n) begin
         m_en = 0; m_pol = 0; m_irqen = 0; m_ovr = 0; m_done = 0; m_irq = 0;
         m_len = 0; m_scr = 0; m_cnt = 0; m_left = 0; pw_valid = 0;
         return;
      end
      m_irq    = m_done & m_irqen;
      busy     = (m_left != 0);
      word     = pw_valid ? int'(pw_addr[4:2]) : -1;
      en_new   = m_en;
      fire     = 0;
      done_set = 0;
      if (word == 0 && pw_strb[0]) begin
         en_new = pw_data[0];
         fire   = pw_data[1];
      end
      if (busy) begin
         if (!en_new) m_left = 0;
         else begin
            m_left--;
            done_set = (m_left == 0);
         end
      end
      case (word)
         0: if (pw_strb[0]) begin
               m_en  = pw_data[0];
               m_pol = pw_data[2];
               if (IRQ_ON) m_irqen = pw_data[3];
            end
         1: m_len = merge(m_len, pw_data, pw_strb);
         2: m_scr = merge(m_scr, pw_data, pw_strb);
         3: if (pw_strb[0]) begin
               if (pw_data[1]) m_ovr = 0;
               if (IRQ_ON && pw_data[2]) m_done = 0;
            end
         default: ;
      endcase
      if (fire && !busy && en_new && m_len != 0) begin
         m_left = int'(m_len);
         m_cnt++;
      end
      if (fire && busy) m_ovr = 1;
      if (IRQ_ON && done_set) m_done = 1;
      pw_valid = 0;
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   always @(negedge clk) begin
      if (sol_chk_on) begin
         chk("sol_out", sol_out, m_pol ^ (m_left != 0));
`ifdef SOL_REGS_IRQ_EN
         chk("irq", irq, m_irq);
`endif
      end
   end

   task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int w_lead, input int b_delay);
      bit aw_done, w_done, aw_hs, w_hs;
      int cyc, t;
      aw_done = 0; w_done = 0; cyc = 0;
      while (!(aw_done && w_done)) begin
         @(negedge clk);
         if (!w_done) begin wvalid = 1; wdata = data; wstrb = strb; end
         if (!aw_done && cyc >= w_lead) begin awvalid = 1; awaddr = addr; end
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         @(posedge clk);
         if (aw_hs) aw_done = 1;
         if (w_hs)  w_done  = 1;
         cyc++;
         #1;
         if (aw_done) awvalid = 0;
         if (w_done)  wvalid  = 0;
         if (cyc > 40) begin
            chk("wr_handshake", {30'h0, aw_done, w_done}, 32'h3);
            awvalid = 0; wvalid = 0;
            return;
         end
      end
      pw_addr = addr; pw_data = data; pw_strb = strb; pw_valid = 1;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!bvalid && t < 10);
      chk("bvalid", bvalid, 1);
      chk("bresp", bresp, addr[4] ? 2 : 0);
      repeat (b_delay) begin
         @(negedge clk);
         chk("bvalid_hold", bvalid, 1);
      end
      bready = 1;
      @(posedge clk);
      #1 bready = 0;
      @(negedge clk);
      chk("bvalid_drop", bvalid, 0);
   endtask

   task automatic axi_read(input logic [4:0] addr, output logic [31:0] data);
      logic [33:0] exp;
      int t;
      @(negedge clk);
      arvalid = 1; araddr = addr; t = 0;
      while (!arready && t < 20) begin
         @(negedge clk);
         t++;
      end
      exp = model_read(addr);
      @(posedge clk);
      #1 arvalid = 0;
      @(negedge clk);
      chk("rvalid", rvalid, 1);
      chk($sformatf("rdata@%02h", addr), rdata, exp[31:0]);
      chk("rresp", rresp, {30'h0, exp[33:32]});
      data = rdata;
      rready = 1;
      @(posedge clk);
      #1 rready = 0;
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d, w, sd;
      logic [3:0]  s;
      logic [4:0]  a;
      int op;
      rst_n = 0; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
      bready = 0; araddr = 0; arprot = 0; arvalid = 0; rready = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      sol_chk_on = 1;

      @(negedge clk);
      chk("rst_bvalid", bvalid, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_awready", awready, 1);
      for (int i = 0; i < 4; i++) begin
         a = 5'(i * 4);
         axi_read(a, d);
         chk("rst_reg", d, 32'h0);
      end

      axi_write(5'h00, 32'h1, 4'hF, 0, 0);
      axi_write(5'h04, 32'h2, 4'hF, 0, 0);
      axi_write(5'h08, 32'h3, 4'hF, 0, 0);
      axi_write(5'h0C, 32'h4, 4'hF, 0, 0);
      axi_read(5'h00, d); chk("ctrl_rb", d, 32'h1);
      axi_read(5'h04, d); chk("len_rb", d, 32'h2);
      axi_read(5'h08, d); chk("scr_rb", d, 32'h3);
      axi_read(5'h0C, d); chk("stat_rb", d, 32'h0);

      axi_write(5'h08, 32'hFFFF_FFFF, 4'hF, 0, 0);
      axi_write(5'h08, 32'hA5A5_A5A5, 4'b0101, 2, 3);
      axi_read(5'h08, d); chk("strb_merge", d, 32'hFFA5_FFA5);

      axi_write(5'h04, 32'd10, 4'hF, 0, 0);
      axi_write(5'h00, 32'h3, 4'hF, 0, 0);
      axi_read(5'h0C, d); chk("stat_mid", d, 32'h0001_0001);
      repeat (20) @(negedge clk);
      axi_read(5'h0C, d); chk("stat_after", d, 32'h0001_0000);
      axi_write(5'h00, 32'h3, 4'hF, 0, 0);
      axi_write(5'h00, 32'h3, 4'hF, 0, 0);
      axi_read(5'h0C, d); chk("stat_overrun", d, 32'h0002_0003);
      repeat (20) @(negedge clk);
      axi_read(5'h0C, d); chk("stat_ovr_idle", d, 32'h0002_0002);
      axi_write(5'h0C, 32'h2, 4'hF, 0, 0);
      axi_read(5'h0C, d); chk("stat_w1c", d, 32'h0002_0000);

      axi_read(5'h14, d); chk("unmapped_rdata", d, 32'h0);
      axi_write(5'h1C, 32'hFFFF_FFFF, 4'hF, 0, 1);
      for (int i = 0; i < 4; i++) begin
         a = 5'(i * 4);
         axi_read(a, d);
      end

      for (int i = 0; i < 220; i++) begin
         op = $urandom_range(0, 9);
         w  = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 7);
         sd = $urandom;
         a  = {w[2:0], sd[1:0]};
         case (w[2:0])
            3'd0:    d = ($urandom & 32'hF) | (($urandom_range(0, 3) != 0) ? 32'h1 : 32'h0);
            3'd1:    d = $urandom_range(0, 12);
            default: d = $urandom;
         endcase
         s = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
         if (op < 5) axi_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2));
         else        axi_read(a, d);
         repeat ($urandom_range(0, 6)) @(negedge clk);
      end

      axi_write(5'h04, 32'd50, 4'hF, 0, 0);
      axi_write(5'h00, 32'h3, 4'hF, 0, 0);
      @(negedge clk);
      arvalid = 1; araddr = 5'h0C;
      awvalid = 1; awaddr = 5'h08;
      @(posedge clk);
      #1 arvalid = 0; awvalid = 0;
      @(negedge clk);
      rst_n = 0;
      @(posedge clk);
      @(negedge clk);
      chk("rstmid_rvalid", rvalid, 0);
      chk("rstmid_bvalid", bvalid, 0);
      chk("rstmid_sol", sol_out, 0);
      chk("rstmid_awready", awready, 1);
      rst_n = 1;
      for (int i = 0; i < 4; i++) begin
         a = 5'(i * 4);
         axi_read(a, d);
         chk("rstmid_reg", d, 32'h0);
      end
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
